// File: rtl/controle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | controle_pkg: encodings shared by the multicycle MIPS32 control unit  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package controle_pkg;

   localparam logic [5:0] c_op_r    = 6'b000000;
   localparam logic [5:0] c_op_lw   = 6'b100011;
   localparam logic [5:0] c_op_sw   = 6'b101011;
   localparam logic [5:0] c_op_beq  = 6'b000100;
   localparam logic [5:0] c_op_j    = 6'b000010;
   localparam logic [5:0] c_op_addi = 6'b001000;
   localparam logic [5:0] c_op_andi = 6'b001100;
   localparam logic [5:0] c_op_ori  = 6'b001101;
   localparam logic [5:0] c_op_lui  = 6'b001111;

   localparam logic [3:0] c_st_inicio   = 4'd0;
   localparam logic [3:0] c_st_busca    = 4'd1;
   localparam logic [3:0] c_st_decode   = 4'd2;
   localparam logic [3:0] c_st_exec_r   = 4'd3;
   localparam logic [3:0] c_st_wb_r     = 4'd4;
   localparam logic [3:0] c_st_endereco = 4'd5;
   localparam logic [3:0] c_st_mem_le   = 4'd6;
   localparam logic [3:0] c_st_wb_mem   = 4'd7;
   localparam logic [3:0] c_st_mem_esc  = 4'd8;
   localparam logic [3:0] c_st_desvio   = 4'd9;
   localparam logic [3:0] c_st_salto    = 4'd10;
   localparam logic [3:0] c_st_exec_i   = 4'd11;
   localparam logic [3:0] c_st_wb_i     = 4'd12;
   localparam logic [3:0] c_st_excecao  = 4'd13;

   localparam logic [2:0] c_alu_add   = 3'b000;
   localparam logic [2:0] c_alu_sub   = 3'b001;
   localparam logic [2:0] c_alu_funct = 3'b010;
   localparam logic [2:0] c_alu_and   = 3'b011;
   localparam logic [2:0] c_alu_or    = 3'b100;
   localparam logic [2:0] c_alu_passb = 3'b101;

   localparam logic [1:0] c_ext_sinal  = 2'b00;
   localparam logic [1:0] c_ext_zero   = 2'b01;
   localparam logic [1:0] c_ext_sup    = 2'b10;
   localparam logic [1:0] c_ext_desvio = 2'b11;

   localparam logic [1:0] c_srcb_b      = 2'b00;
   localparam logic [1:0] c_srcb_4      = 2'b01;
   localparam logic [1:0] c_srcb_imm    = 2'b10;
   localparam logic [1:0] c_srcb_desvio = 2'b11;

   localparam logic [1:0] c_pcs_alu    = 2'b00;
   localparam logic [1:0] c_pcs_aluout = 2'b01;
   localparam logic [1:0] c_pcs_salto  = 2'b10;

   // I-type immediate handling: {ext_modo, alu_op}
   function automatic logic [4:0] cfg_tipo_i(input logic [5:0] op);
      logic [4:0] cfg;
      case (op)
         c_op_andi: cfg = {c_ext_zero, c_alu_and};
         c_op_ori:  cfg = {c_ext_zero, c_alu_or};
         c_op_lui:  cfg = {c_ext_sup, c_alu_passb};
         default:   cfg = {c_ext_sinal, c_alu_add};
      endcase
      return cfg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decodificador_saidas.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decodificador_saidas: state (+opcode, mem_pronto) to control word     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module decodificador_saidas
   import controle_pkg::*;
(
   input  logic [3:0] estado,
   input  logic [5:0] opcode,
   input  logic       mem_pronto,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic [1:0] ext_modo,
   output logic       excecao
);

   logic [4:0] w_cfg_i;
   assign w_cfg_i = cfg_tipo_i(opcode);

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = c_srcb_b;
      alu_op        = c_alu_add;
      pc_source     = c_pcs_alu;
      ext_modo      = c_ext_sinal;
      excecao       = 1'b0;
      case (estado)
         c_st_busca: begin
            mem_read  = 1'b1;
            alu_src_b = c_srcb_4;
            ir_write  = mem_pronto;
            pc_write  = mem_pronto;
         end
         c_st_decode: begin
            alu_src_b = c_srcb_desvio;
            ext_modo  = c_ext_desvio;
         end
         c_st_exec_r: begin
            alu_src_a = 1'b1;
            alu_op    = c_alu_funct;
         end
         c_st_wb_r: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         c_st_endereco: begin
            alu_src_a = 1'b1;
            alu_src_b = c_srcb_imm;
         end
         c_st_mem_le: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         c_st_wb_mem: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         c_st_mem_esc: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         c_st_desvio: begin
            alu_src_a     = 1'b1;
            alu_op        = c_alu_sub;
            pc_write_cond = 1'b1;
            pc_source     = c_pcs_aluout;
         end
         c_st_salto: begin
            pc_write  = 1'b1;
            pc_source = c_pcs_salto;
         end
         c_st_exec_i: begin
            alu_src_a = 1'b1;
            alu_src_b = c_srcb_imm;
            {ext_modo, alu_op} = w_cfg_i;
         end
         c_st_wb_i: begin
            reg_write = 1'b1;
            {ext_modo, alu_op} = w_cfg_i;
         end
         c_st_excecao: begin
            excecao = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unidade_controle_multiciclo: multicycle MIPS32 control FSM            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module unidade_controle_multiciclo
   import controle_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_pronto,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic [1:0] ext_modo,
   output logic       excecao,
   output logic [3:0] estado
);

   logic [3:0] r_estado;
   logic [3:0] w_prox;

   // The branch decision is taken in the datapath (pc_write_cond AND zero).
   logic w_zero_unused;
   assign w_zero_unused = zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_estado <= c_st_inicio;
      else        r_estado <= w_prox;
   end

   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         c_st_inicio:   w_prox = c_st_busca;
         c_st_busca:    if (mem_pronto) w_prox = c_st_decode;
         c_st_decode: begin
            case (opcode)
               c_op_r:                                    w_prox = c_st_exec_r;
               c_op_lw, c_op_sw:                          w_prox = c_st_endereco;
               c_op_beq:                                  w_prox = c_st_desvio;
               c_op_j:                                    w_prox = c_st_salto;
               c_op_addi, c_op_andi, c_op_ori, c_op_lui:  w_prox = c_st_exec_i;
               default:                                   w_prox = c_st_excecao;
            endcase
         end
         c_st_exec_r:   w_prox = c_st_wb_r;
         c_st_wb_r:     w_prox = c_st_busca;
         c_st_endereco: w_prox = (opcode == c_op_lw) ? c_st_mem_le : c_st_mem_esc;
         c_st_mem_le:   if (mem_pronto) w_prox = c_st_wb_mem;
         c_st_wb_mem:   w_prox = c_st_busca;
         c_st_mem_esc:  if (mem_pronto) w_prox = c_st_busca;
         c_st_desvio:   w_prox = c_st_busca;
         c_st_salto:    w_prox = c_st_busca;
         c_st_exec_i:   w_prox = c_st_wb_i;
         c_st_wb_i:     w_prox = c_st_busca;
         c_st_excecao:  w_prox = c_st_excecao;
         // Unused encodings trap rather than run on corrupted state
         default:       w_prox = c_st_excecao;
      endcase
   end

   assign estado = r_estado;

   decodificador_saidas u_dec (
      .estado        (r_estado),
      .opcode        (opcode),
      .mem_pronto    (mem_pronto),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .ext_modo      (ext_modo),
      .excecao       (excecao)
   );

endmodule
`default_nettype wire
